// File: rtl/gb_dma_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gb_dma_pkg
// Description : Shared types and constants for the GBC HDMA/GDMA copy path.
// Revision    : 1.0  initial release
// ============================================================================
package gb_dma_pkg;

  // Copy engine byte phases
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WAIT  = 2'd2,
    WRITE = 2'd3
  } dma_st_t;

  // Echo RAM window and the offset that folds it back onto 0xA000-0xBFFF
  localparam logic [15:0] ECHO_BASE = 16'hE000;
  localparam logic [15:0] ECHO_OFS  = 16'h4000;

  // VRAM byte address width
  localparam int VRAM_AW = 13;

  // Fold echo-area sources down by 0x4000; everything else passes through
  function automatic logic [15:0] echo_remap(input logic [15:0] addr);
    echo_remap = (addr >= ECHO_BASE) ? (addr - ECHO_OFS) : addr;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hdma_copy.sv
`default_nettype none
// ============================================================================
// Module      : hdma_copy
// Description : Byte-copy engine behind the HDMA/GDMA register block. One
//               system-bus read and one VRAM write per requested byte, with a
//               single-entry pending slot and a sticky overflow flag.
// Revision    : 1.0  initial release
// ============================================================================
module hdma_copy
  import gb_dma_pkg::*;
#(
  parameter int RD_LAT = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 hdma_rd,
  input  logic [15:0]          hdma_source_addr,
  input  logic [15:0]          hdma_target_addr,
  output logic [15:0]          src_addr,
  output logic                 src_rd,
  input  logic [7:0]           src_din,
  output logic [VRAM_AW-1:0]   vram_addr,
  output logic                 vram_wr,
  output logic [7:0]           vram_dout,
  output logic                 cpu_stall,
  output logic [11:0]          xfer_count,
  output logic                 overflow
);

  // Any RD_LAT other than 1 takes the extra WAIT cycle
  localparam logic HAS_WAIT = (RD_LAT != 1);

  dma_st_t              st;
  dma_st_t              st_nxt;

  logic                 prev_rd;
  logic [15:0]          prev_src;
  logic                 req;

  logic                 pend_vld;
  logic [15:0]          pend_src;
  logic [VRAM_AW-1:0]   pend_tgt;

  logic                 start;
  logic [15:0]          sel_src;
  logic [VRAM_AW-1:0]   sel_tgt;

  // Target is always inside 0x8000-0x9FFF, so the top bits carry no information
  logic                 unused_tgt_hi;
  assign unused_tgt_hi = ^hdma_target_addr[15:VRAM_AW];

  // A new byte is wanted on the rising edge of hdma_rd or on any source step
  assign req = hdma_rd & (~prev_rd | (hdma_source_addr != prev_src));

  // A fresh request takes priority over the pending slot when idle
  assign sel_src = req ? hdma_source_addr : pend_src;
  assign sel_tgt = req ? hdma_target_addr[VRAM_AW-1:0] : pend_tgt;

  // Next-state decode; start flags the IDLE->READ hand-off
  always_comb begin
    st_nxt = st;
    start  = 1'b0;
    case (st)
      IDLE: begin
        if (req || pend_vld) begin
          st_nxt = READ;
          start  = 1'b1;
        end
      end
      READ:    st_nxt = HAS_WAIT ? WAIT : WRITE;
      WAIT:    st_nxt = WRITE;
      WRITE:   st_nxt = IDLE;
      default: st_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) st <= IDLE;
    else       st <= st_nxt;
  end

  // Previous-cycle copies of the trigger inputs for edge/change detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_rd  <= 1'b0;
      prev_src <= 16'h0000;
    end else begin
      prev_rd  <= hdma_rd;
      prev_src <= hdma_source_addr;
    end
  end

  // Latch the active byte's addresses when leaving IDLE; they hold until the next byte
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_addr  <= 16'h0000;
      vram_addr <= '0;
    end else if (start) begin
      src_addr  <= echo_remap(sel_src);
      vram_addr <= sel_tgt;
    end
  end

  // Single-entry pending slot; a request that finds it full is lost and flagged
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_vld <= 1'b0;
      pend_src <= 16'h0000;
      pend_tgt <= '0;
      overflow <= 1'b0;
    end else if (req && (st != IDLE)) begin
      if (pend_vld) begin
        overflow <= 1'b1;
      end else begin
        pend_vld <= 1'b1;
        pend_src <= hdma_source_addr;
        pend_tgt <= hdma_target_addr[VRAM_AW-1:0];
      end
    end else if ((st == IDLE) && !req && pend_vld) begin
      pend_vld <= 1'b0;
    end
  end

  // Count completed VRAM writes; wraps naturally at 4096
  always_ff @(posedge clk or posedge reset) begin
    if (reset)             xfer_count <= 12'd0;
    else if (st == WRITE)  xfer_count <= xfer_count + 12'd1;
  end

  // Strobes decode straight from the state so an async reset kills them at once
  assign src_rd    = (st == READ);
  assign vram_wr   = (st == WRITE);
  assign vram_dout = vram_wr ? src_din : 8'h00;
  assign cpu_stall = ~reset & (hdma_rd | (st != IDLE) | pend_vld);

endmodule
`default_nettype wire

// File: tb/tb_hdma_copy.sv
`default_nettype none
// ============================================================================
// Module      : tb_hdma_copy
// Description : Directed scoreboard bench for hdma_copy (RD_LAT=2 and RD_LAT=1).
// Revision    : 1.0  initial release
// ============================================================================
module tb_hdma_copy;

  logic        clk = 1'b0;
  logic        reset;

  // Primary DUT, RD_LAT = 2
  logic        hdma_rd;
  logic [15:0] hdma_source_addr, hdma_target_addr;
  logic [15:0] src_addr;
  logic        src_rd;
  logic [7:0]  src_din;
  logic [12:0] vram_addr;
  logic        vram_wr;
  logic [7:0]  vram_dout;
  logic        cpu_stall;
  logic [11:0] xfer_count;
  logic        overflow;

  // Secondary DUT, RD_LAT = 1
  logic        hdma_rd_b;
  logic [15:0] src_b, tgt_b;
  logic [15:0] src_addr_b;
  logic        src_rd_b;
  logic [7:0]  src_din_b;
  logic [12:0] vram_addr_b;
  logic        vram_wr_b;
  logic [7:0]  vram_dout_b;
  logic        cpu_stall_b;
  logic [11:0] xfer_count_b;
  logic        overflow_b;

  hdma_copy #(.RD_LAT(2)) dut (
    .clk(clk), .reset(reset), .hdma_rd(hdma_rd),
    .hdma_source_addr(hdma_source_addr), .hdma_target_addr(hdma_target_addr),
    .src_addr(src_addr), .src_rd(src_rd), .src_din(src_din),
    .vram_addr(vram_addr), .vram_wr(vram_wr), .vram_dout(vram_dout),
    .cpu_stall(cpu_stall), .xfer_count(xfer_count), .overflow(overflow)
  );

  hdma_copy #(.RD_LAT(1)) dut_b (
    .clk(clk), .reset(reset), .hdma_rd(hdma_rd_b),
    .hdma_source_addr(src_b), .hdma_target_addr(tgt_b),
    .src_addr(src_addr_b), .src_rd(src_rd_b), .src_din(src_din_b),
    .vram_addr(vram_addr_b), .vram_wr(vram_wr_b), .vram_dout(vram_dout_b),
    .cpu_stall(cpu_stall_b), .xfer_count(xfer_count_b), .overflow(overflow_b)
  );

  always #5 clk = ~clk;

  // Bus models: data = low byte of the read address, RD_LAT cycles later
  logic [7:0] rd_d1, rd_d2, rd_b1;
  always @(posedge clk) begin
    if (src_rd)   rd_d1 <= src_addr[7:0];
    rd_d2 <= rd_d1;
    if (src_rd_b) rd_b1 <= src_addr_b[7:0];
  end
  assign src_din   = rd_d2;
  assign src_din_b = rd_b1;

  int errors = 0;
  int checks = 0;
  int wr_seen = 0;

  logic [15:0] q_src[$];
  logic [20:0] q_wr[$];
  logic [20:0] exp_wr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor for the primary DUT
  always @(negedge clk) begin
    if (!reset) begin
      if (src_rd) begin
        if (q_src.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_src_rd: got src_addr 0x%0h with no request queued", src_addr);
        end else begin
          chk("src_addr", 32'(src_addr), 32'(q_src.pop_front()));
        end
      end
      if (vram_wr) begin
        wr_seen++;
        if (q_wr.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_vram_wr: got addr 0x%0h data 0x%0h with nothing queued", vram_addr, vram_dout);
        end else begin
          exp_wr = q_wr.pop_front();
          chk("vram_addr", 32'(vram_addr), 32'(exp_wr[20:8]));
          chk("vram_dout", 32'(vram_dout), 32'(exp_wr[7:0]));
        end
      end
      if (src_rd || vram_wr)
        chk("rd_wr_overlap", 32'(src_rd & vram_wr), 32'd0);
    end
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  int base_wr;
  logic [11:0] base_cnt;

  task automatic chk_all_zero(input string tag);
    chk({tag, "_src_rd"},     32'(src_rd),     32'd0);
    chk({tag, "_vram_wr"},    32'(vram_wr),    32'd0);
    chk({tag, "_cpu_stall"},  32'(cpu_stall),  32'd0);
    chk({tag, "_xfer_count"}, 32'(xfer_count), 32'd0);
    chk({tag, "_overflow"},   32'(overflow),   32'd0);
    chk({tag, "_src_addr"},   32'(src_addr),   32'd0);
    chk({tag, "_vram_addr"},  32'(vram_addr),  32'd0);
    chk({tag, "_vram_dout"},  32'(vram_dout),  32'd0);
  endtask

  initial begin
    reset = 1'b1;
    hdma_rd = 1'b0; hdma_source_addr = 16'h0000; hdma_target_addr = 16'h8000;
    hdma_rd_b = 1'b0; src_b = 16'h0000; tgt_b = 16'h8000;
    repeat (2) tick();
    @(negedge clk);
    chk_all_zero("reset");
    tick();
    reset = 1'b0;
    tick();

    // GDMA burst of 0x20 bytes, one source step every 4 clocks
    base_wr = wr_seen;
    hdma_rd = 1'b1;
    for (int n = 0; n < 32; n++) begin
      hdma_source_addr = 16'h2040 + 16'(n);
      hdma_target_addr = 16'h8200 + 16'(n);
      q_src.push_back(16'h2040 + 16'(n));
      q_wr.push_back({13'h0200 + 13'(n), 8'h40 + 8'(n)});
      repeat (4) tick();
    end
    hdma_rd = 1'b0;
    repeat (8) tick();
    chk("gdma_writes",    32'(wr_seen - base_wr), 32'd32);
    chk("gdma_count",     32'(xfer_count),        32'd32);
    chk("gdma_overflow",  32'(overflow),          32'd0);
    chk("gdma_stall_end", 32'(cpu_stall),         32'd0);

    // Echo remap and the boundary just below it
    hdma_rd = 1'b1; hdma_source_addr = 16'hE010; hdma_target_addr = 16'h8010;
    q_src.push_back(16'hA010); q_wr.push_back({13'h0010, 8'h10});
    tick();
    hdma_rd = 1'b0;
    repeat (6) tick();
    hdma_rd = 1'b1; hdma_source_addr = 16'hDFFF; hdma_target_addr = 16'h9FFF;
    q_src.push_back(16'hDFFF); q_wr.push_back({13'h1FFF, 8'hFF});
    tick();
    hdma_rd = 1'b0;
    repeat (6) tick();

    // Latency with RD_LAT = 2
    hdma_rd = 1'b1; hdma_source_addr = 16'h3000; hdma_target_addr = 16'h8300;
    q_src.push_back(16'h3000); q_wr.push_back({13'h0300, 8'h00});
    @(negedge clk); chk("lat2_t_src_rd",  32'(src_rd),  32'd0);
    @(negedge clk); chk("lat2_t1_src_rd", 32'(src_rd),  32'd1);
                    chk("lat2_t1_vram_wr",32'(vram_wr), 32'd0);
    @(negedge clk); chk("lat2_t2_vram_wr",32'(vram_wr), 32'd0);
                    chk("lat2_t2_stall",  32'(cpu_stall), 32'd1);
    @(negedge clk); chk("lat2_t3_vram_wr",32'(vram_wr), 32'd1);
    tick();
    hdma_rd = 1'b0;
    repeat (4) tick();

    // Latency with RD_LAT = 1
    hdma_rd_b = 1'b1; src_b = 16'h3155; tgt_b = 16'h8155;
    @(negedge clk); chk("lat1_t_src_rd",   32'(src_rd_b),    32'd0);
    @(negedge clk); chk("lat1_t1_src_rd",  32'(src_rd_b),    32'd1);
                    chk("lat1_t1_addr",    32'(src_addr_b),  32'h3155);
                    chk("lat1_t1_vram_wr", 32'(vram_wr_b),   32'd0);
    @(negedge clk); chk("lat1_t2_vram_wr", 32'(vram_wr_b),   32'd1);
                    chk("lat1_t2_addr",    32'(vram_addr_b), 32'h0155);
                    chk("lat1_t2_dout",    32'(vram_dout_b), 32'h55);
    @(negedge clk); chk("lat1_t3_vram_wr", 32'(vram_wr_b),   32'd0);
                    chk("lat1_t3_count",   32'(xfer_count_b),32'd1);
    tick();
    hdma_rd_b = 1'b0;
    repeat (4) tick();

    // hdma_rd drops during WAIT: the write still lands, stall falls right after
    hdma_rd = 1'b1; hdma_source_addr = 16'h4077; hdma_target_addr = 16'h8477;
    q_src.push_back(16'h4077); q_wr.push_back({13'h0477, 8'h77});
    tick();
    tick();
    hdma_rd = 1'b0;
    @(negedge clk); chk("drop_wait_stall",  32'(cpu_stall), 32'd1);
    tick();
    @(negedge clk); chk("drop_write",       32'(vram_wr),   32'd1);
                    chk("drop_write_stall", 32'(cpu_stall), 32'd1);
    tick();
    @(negedge clk); chk("drop_stall_fall",  32'(cpu_stall), 32'd0);
    repeat (3) tick();

    // Overflow: four source steps on consecutive clocks
    base_wr  = wr_seen;
    base_cnt = xfer_count;
    hdma_rd = 1'b1; hdma_source_addr = 16'h5010; hdma_target_addr = 16'h8510;
    q_src.push_back(16'h5010); q_wr.push_back({13'h0510, 8'h10});
    tick();
    hdma_source_addr = 16'h5011; hdma_target_addr = 16'h8511;
    q_src.push_back(16'h5011); q_wr.push_back({13'h0511, 8'h11});
    tick();
    hdma_source_addr = 16'h5012; hdma_target_addr = 16'h8512;
    tick();
    hdma_source_addr = 16'h5013; hdma_target_addr = 16'h8513;
    tick();
    chk("ovf_set", 32'(overflow), 32'd1);
    repeat (10) tick();
    hdma_rd = 1'b0;
    repeat (4) tick();
    chk("ovf_sticky", 32'(overflow),                32'd1);
    chk("ovf_writes", 32'(wr_seen - base_wr),        32'd2);
    chk("ovf_count",  32'(12'(xfer_count - base_cnt)), 32'd2);

    // Asynchronous reset during WAIT
    base_wr = wr_seen;
    hdma_rd = 1'b1; hdma_source_addr = 16'h6020; hdma_target_addr = 16'h8620;
    q_src.push_back(16'h6020);
    tick();
    tick();
    #2;
    reset = 1'b1;
    #1;
    chk_all_zero("rst_mid");
    hdma_rd = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    repeat (8) tick();
    chk("rst_no_write", 32'(wr_seen - base_wr), 32'd0);
    chk("rst_count",    32'(xfer_count),        32'd0);
    chk("rst_overflow", 32'(overflow),          32'd0);

    chk("q_src_drained", 32'(q_src.size()), 32'd0);
    chk("q_wr_drained",  32'(q_wr.size()),  32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
